// File: rtl/cu_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : cu_pipe
//  Purpose  : Pipelined RV32I(+M) control unit. Decodes the ID instruction,
//             registers the control word into the ID/EX slot, detects
//             load-use hazards and sequences multi-cycle MUL/DIV occupancy
//             of EX. One stall_o freezes PC and IF/ID; flush_i kills ID/EX.
//  Ports    : clk, rst                 clock / synchronous active-high reset
//             instr_i, valid_i         ID instruction and its valid flag
//             flush_i                  taken branch/jump from EX
//             id_imm_src_o             immediate format for the ID imm gen
//             stall_o                  hold PC and IF/ID this cycle
//             ex_*_o                   registered ID/EX control word
//  Revision : 1.0  initial release
// ============================================================================
module cu_pipe #(
  parameter int M_EXT      = 1,
  parameter int MUL_CYCLES = 1,
  parameter int DIV_CYCLES = 32,
  parameter int RA_W       = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     instr_i,
  input  logic            valid_i,
  input  logic            flush_i,
  output logic [2:0]      id_imm_src_o,
  output logic            stall_o,
  output logic            ex_valid_o,
  output logic            ex_reg_write_o,
  output logic            ex_mem_write_o,
  output logic [3:0]      ex_alu_ctrl_o,
  output logic            ex_alu_src_a_o,
  output logic            ex_alu_src_b_o,
  output logic [1:0]      ex_result_src_o,
  output logic            ex_branch_o,
  output logic            ex_jump_o,
  output logic [2:0]      ex_funct3_o,
  output logic [RA_W-1:0] ex_rd_o,
  output logic            ex_mdu_start_o,
  output logic            ex_illegal_o
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLL  = 4'b0101;
  localparam logic [3:0] ALU_SRL  = 4'b0110;
  localparam logic [3:0] ALU_SRA  = 4'b0111;
  localparam logic [3:0] ALU_SLT  = 4'b1001;
  localparam logic [3:0] ALU_SLTU = 4'b1010;
  localparam logic [3:0] ALU_PASS = 4'b1011;

  // Counter holds LAT-2 at most, so it needs to represent MAX_LAT-2.
  localparam int MAX_LAT = (DIV_CYCLES > MUL_CYCLES) ? DIV_CYCLES : MUL_CYCLES;
  localparam int CNT_W   = (MAX_LAT > 2) ? $clog2(MAX_LAT) : 1;
  localparam logic [CNT_W-1:0] MUL_RELOAD = CNT_W'((MUL_CYCLES > 1) ? MUL_CYCLES - 2 : 0);
  localparam logic [CNT_W-1:0] DIV_RELOAD = CNT_W'((DIV_CYCLES > 1) ? DIV_CYCLES - 2 : 0);
  localparam logic MUL_MULTI = (MUL_CYCLES > 1);
  localparam logic DIV_MULTI = (DIV_CYCLES > 1);

  typedef enum logic [0:0] {
    RUN      = 1'b0,
    MDU_BUSY = 1'b1
  } state_t;

  typedef struct packed {
    logic            valid;
    logic            reg_write;
    logic            mem_write;
    logic [3:0]      alu_ctrl;
    logic            src_a;
    logic            src_b;
    logic [1:0]      result_src;
    logic            branch;
    logic            jump;
    logic [2:0]      funct3;
    logic [RA_W-1:0] rd;
    logic            mdu_start;
    logic            illegal;
  } ex_ctrl_t;

  // Instruction fields
  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [RA_W-1:0] rd_f;
  logic [RA_W-1:0] rs1_f;
  logic [RA_W-1:0] rs2_f;

  assign opcode = instr_i[6:0];
  assign funct3 = instr_i[14:12];
  assign funct7 = instr_i[31:25];
  assign rd_f   = instr_i[7 +: RA_W];
  assign rs1_f  = instr_i[15 +: RA_W];
  assign rs2_f  = instr_i[20 +: RA_W];

  ex_ctrl_t ex_d;
  ex_ctrl_t ex_q;
  state_t   state_q;
  logic [CNT_W-1:0] cnt_q;

  logic [2:0] imm_src;
  logic       is_mdu;
  logic       bad;

  // Base ALU op selected by funct3 (shared by R-type funct7=0 and I-type)
  function automatic logic [3:0] alu_of_f3(input logic [2:0] f3);
    case (f3)
      3'b000:  alu_of_f3 = ALU_ADD;
      3'b001:  alu_of_f3 = ALU_SLL;
      3'b010:  alu_of_f3 = ALU_SLT;
      3'b011:  alu_of_f3 = ALU_SLTU;
      3'b100:  alu_of_f3 = ALU_XOR;
      3'b101:  alu_of_f3 = ALU_SRL;
      3'b110:  alu_of_f3 = ALU_OR;
      default: alu_of_f3 = ALU_AND;
    endcase
  endfunction

  // Decode of the ID instruction into a candidate EX control word
  always_comb begin
    ex_d        = '0;
    ex_d.valid  = 1'b1;
    ex_d.funct3 = funct3;
    imm_src     = 3'b000;
    is_mdu      = 1'b0;
    bad         = 1'b0;
    case (opcode)
      OP_R: begin
        case (funct7)
          7'b0000000: begin
            ex_d.reg_write = 1'b1;
            ex_d.alu_ctrl  = alu_of_f3(funct3);
          end
          7'b0100000: begin
            ex_d.reg_write = 1'b1;
            if (funct3 == 3'b000)      ex_d.alu_ctrl = ALU_SUB;
            else if (funct3 == 3'b101) ex_d.alu_ctrl = ALU_SRA;
            else                       bad = 1'b1;
          end
          7'b0000001: begin
            if (M_EXT != 0) begin
              ex_d.reg_write  = 1'b1;
              ex_d.result_src = 2'b11;
              ex_d.mdu_start  = 1'b1;
              is_mdu          = 1'b1;
            end else begin
              bad = 1'b1;
            end
          end
          default: bad = 1'b1;
        endcase
      end
      OP_I: begin
        ex_d.reg_write = 1'b1;
        ex_d.src_b     = 1'b1;
        ex_d.alu_ctrl  = alu_of_f3(funct3);
        if (funct3 == 3'b001) begin
          imm_src = 3'b001;
          if (funct7[5]) bad = 1'b1;
        end else if (funct3 == 3'b101) begin
          imm_src = 3'b001;
          if (funct7[5]) ex_d.alu_ctrl = ALU_SRA;
        end
      end
      OP_LOAD: begin
        ex_d.reg_write  = 1'b1;
        ex_d.src_b      = 1'b1;
        ex_d.result_src = 2'b01;
      end
      OP_STORE: begin
        ex_d.mem_write = 1'b1;
        ex_d.src_b     = 1'b1;
        imm_src        = 3'b010;
      end
      OP_LUI: begin
        ex_d.reg_write = 1'b1;
        ex_d.src_b     = 1'b1;
        ex_d.alu_ctrl  = ALU_PASS;
        imm_src        = 3'b100;
      end
      OP_AUIPC: begin
        ex_d.reg_write = 1'b1;
        ex_d.src_a     = 1'b1;
        ex_d.src_b     = 1'b1;
        imm_src        = 3'b100;
      end
      OP_JAL: begin
        ex_d.reg_write  = 1'b1;
        ex_d.src_a      = 1'b1;
        ex_d.src_b      = 1'b1;
        ex_d.result_src = 2'b10;
        ex_d.jump       = 1'b1;
        imm_src         = 3'b101;
      end
      OP_JALR: begin
        ex_d.reg_write  = 1'b1;
        ex_d.src_b      = 1'b1;
        ex_d.result_src = 2'b10;
        ex_d.jump       = 1'b1;
      end
      OP_BRANCH: begin
        ex_d.branch = 1'b1;
        ex_d.src_a  = 1'b1;
        ex_d.src_b  = 1'b1;
        imm_src     = 3'b011;
      end
      default: bad = 1'b1;
    endcase
    // rd is only meaningful when the instruction writes; zero it otherwise
    ex_d.rd = ex_d.reg_write ? rd_f : '0;
    if (bad) begin
      ex_d         = '0;
      ex_d.valid   = 1'b1;
      ex_d.illegal = 1'b1;
      is_mdu       = 1'b0;
    end
  end

  assign id_imm_src_o = imm_src;

  // Hazard detection against a load sitting in EX
  logic rs1_used;
  logic rs2_used;
  logic load_use;

  assign rs1_used = !((opcode == OP_LUI) || (opcode == OP_AUIPC) || (opcode == OP_JAL));
  assign rs2_used = (opcode == OP_R) || (opcode == OP_STORE) || (opcode == OP_BRANCH);
  assign load_use = (state_q == RUN) && ex_q.valid && (ex_q.result_src == 2'b01) &&
                    (ex_q.rd != '0) && valid_i &&
                    ((rs1_used && (rs1_f == ex_q.rd)) || (rs2_used && (rs2_f == ex_q.rd)));

  // Flush and reset dominate so a killed MDU op never leaves a residual stall
  assign stall_o = !rst && !flush_i && ((state_q == MDU_BUSY) || load_use);

  // LAT>1 selection from funct3[2]: DIV/REM family vs MUL family
  logic             lat_multi;
  logic [CNT_W-1:0] lat_reload;
  assign lat_multi  = funct3[2] ? DIV_MULTI : MUL_MULTI;
  assign lat_reload = funct3[2] ? DIV_RELOAD : MUL_RELOAD;

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q    <= '0;
      state_q <= RUN;
      cnt_q   <= '0;
    end else if (flush_i) begin
      ex_q    <= '0;
      state_q <= RUN;
      cnt_q   <= '0;
    end else if (state_q == MDU_BUSY) begin
      ex_q.mdu_start <= 1'b0;
      if (cnt_q == '0) state_q <= RUN;
      else             cnt_q   <= cnt_q - 1'b1;
    end else if (load_use) begin
      ex_q <= '0;
    end else if (valid_i) begin
      ex_q <= ex_d;
      if (is_mdu && lat_multi) begin
        state_q <= MDU_BUSY;
        cnt_q   <= lat_reload;
      end
    end else begin
      ex_q <= '0;
    end
  end

  assign ex_valid_o      = ex_q.valid;
  assign ex_reg_write_o  = ex_q.reg_write;
  assign ex_mem_write_o  = ex_q.mem_write;
  assign ex_alu_ctrl_o   = ex_q.alu_ctrl;
  assign ex_alu_src_a_o  = ex_q.src_a;
  assign ex_alu_src_b_o  = ex_q.src_b;
  assign ex_result_src_o = ex_q.result_src;
  assign ex_branch_o     = ex_q.branch;
  assign ex_jump_o       = ex_q.jump;
  assign ex_funct3_o     = ex_q.funct3;
  assign ex_rd_o         = ex_q.rd;
  assign ex_mdu_start_o  = ex_q.mdu_start;
  assign ex_illegal_o    = ex_q.illegal;

endmodule
`default_nettype wire

// File: tb/tb_cu_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cu_pipe
//  Purpose  : Directed self-checking bench for cu_pipe. A second instance
//             with M_EXT=0 shares the stimulus for the illegal-MDU case.
//  Revision : 1.0  initial release
// ============================================================================
module tb_cu_pipe;

  localparam logic [31:0] I_LW_X5   = 32'h0000A283; // lw   x5,0(x1)
  localparam logic [31:0] I_LW_X0   = 32'h0000A003; // lw   x0,0(x1)
  localparam logic [31:0] I_ADD     = 32'h00228333; // add  x6,x5,x2
  localparam logic [31:0] I_ADD_X0  = 32'h00200333; // add  x6,x0,x2
  localparam logic [31:0] I_DIV     = 32'h025241B3; // div  x3,x4,x5
  localparam logic [31:0] I_MUL     = 32'h023100B3; // mul  x1,x2,x3
  localparam logic [31:0] I_SRAI    = 32'h40315093; // srai x1,x2,3
  localparam logic [31:0] I_SLLI_BAD= 32'h40311093; // slli with funct7[5]=1
  localparam logic [31:0] I_AUIPC   = 32'h12345397; // auipc x7,0x12345
  localparam logic [31:0] I_SW      = 32'h0020A223; // sw   x2,4(x1)
  localparam logic [31:0] I_BAD     = 32'h0000007F;
  localparam logic [31:0] I_NOP     = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr;
  logic        valid;
  logic        flush;

  logic [2:0] imm_src, nm_imm_src;
  logic       stall, nm_stall;
  logic       ex_valid, nm_valid;
  logic       ex_rw, nm_rw;
  logic       ex_mw, nm_mw;
  logic [3:0] ex_alu, nm_alu;
  logic       ex_sa, nm_sa;
  logic       ex_sb, nm_sb;
  logic [1:0] ex_res, nm_res;
  logic       ex_br, nm_br;
  logic       ex_jmp, nm_jmp;
  logic [2:0] ex_f3, nm_f3;
  logic [4:0] ex_rd, nm_rd;
  logic       ex_start, nm_start;
  logic       ex_ill, nm_ill;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  cu_pipe #(.M_EXT(1), .MUL_CYCLES(1), .DIV_CYCLES(32), .RA_W(5)) dut (
    .clk(clk), .rst(rst), .instr_i(instr), .valid_i(valid), .flush_i(flush),
    .id_imm_src_o(imm_src), .stall_o(stall), .ex_valid_o(ex_valid),
    .ex_reg_write_o(ex_rw), .ex_mem_write_o(ex_mw), .ex_alu_ctrl_o(ex_alu),
    .ex_alu_src_a_o(ex_sa), .ex_alu_src_b_o(ex_sb), .ex_result_src_o(ex_res),
    .ex_branch_o(ex_br), .ex_jump_o(ex_jmp), .ex_funct3_o(ex_f3),
    .ex_rd_o(ex_rd), .ex_mdu_start_o(ex_start), .ex_illegal_o(ex_ill)
  );

  cu_pipe #(.M_EXT(0), .MUL_CYCLES(1), .DIV_CYCLES(32), .RA_W(5)) dut_nm (
    .clk(clk), .rst(rst), .instr_i(instr), .valid_i(valid), .flush_i(flush),
    .id_imm_src_o(nm_imm_src), .stall_o(nm_stall), .ex_valid_o(nm_valid),
    .ex_reg_write_o(nm_rw), .ex_mem_write_o(nm_mw), .ex_alu_ctrl_o(nm_alu),
    .ex_alu_src_a_o(nm_sa), .ex_alu_src_b_o(nm_sb), .ex_result_src_o(nm_res),
    .ex_branch_o(nm_br), .ex_jump_o(nm_jmp), .ex_funct3_o(nm_f3),
    .ex_rd_o(nm_rd), .ex_mdu_start_o(nm_start), .ex_illegal_o(nm_ill)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one clock and sample 1 time unit after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int n_res;
  int n_stall;
  int n_start;

  initial begin
    rst = 1'b1; instr = I_NOP; valid = 1'b0; flush = 1'b0;
    tick(); tick();
    chk("rst_valid", {31'd0, ex_valid}, 32'd0);
    chk("rst_rw", {31'd0, ex_rw}, 32'd0);
    chk("rst_res", {30'd0, ex_res}, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    rst = 1'b0;

    // Load-use: one bubble, then the consumer enters EX
    instr = I_LW_X5; valid = 1'b1; #1;
    chk("lw_imm", {29'd0, imm_src}, 32'd0);
    chk("lw_nostall", {31'd0, stall}, 32'd0);
    tick();
    chk("lw_ex_res", {30'd0, ex_res}, 32'd1);
    chk("lw_ex_rd", {27'd0, ex_rd}, 32'd5);
    instr = I_ADD; #1;
    chk("lu_stall", {31'd0, stall}, 32'd1);
    tick();
    chk("lu_bubble", {31'd0, ex_valid}, 32'd0);
    chk("lu_stall_once", {31'd0, stall}, 32'd0);
    tick();
    chk("lu_add_valid", {31'd0, ex_valid}, 32'd1);
    chk("lu_add_rd", {27'd0, ex_rd}, 32'd6);
    chk("lu_add_alu", {28'd0, ex_alu}, 32'd0);
    chk("lu_add_rw", {31'd0, ex_rw}, 32'd1);

    // Load to x0 never stalls
    instr = I_LW_X0; tick();
    instr = I_ADD_X0; #1;
    chk("x0_nostall", {31'd0, stall}, 32'd0);
    tick();
    chk("x0_add_rd", {27'd0, ex_rd}, 32'd6);

    // DIV occupancy: 32 EX cycles, 31 stall cycles, single start pulse
    instr = I_DIV; tick();
    instr = I_NOP; #1;
    n_res = 0; n_stall = 0; n_start = 0;
    for (int i = 0; i < 100 && ex_res == 2'b11; i++) begin
      n_res++;
      if (stall) n_stall++;
      if (ex_start) n_start++;
      tick();
    end
    chk("div_ex_cycles", n_res, 32'd32);
    chk("div_stall_cycles", n_stall, 32'd31);
    chk("div_start_pulses", n_start, 32'd1);
    chk("div_after_valid", {31'd0, ex_valid}, 32'd1);
    chk("div_after_res", {30'd0, ex_res}, 32'd0);

    // MUL with single-cycle latency: no stall; M_EXT=0 instance flags illegal
    instr = I_MUL; #1;
    chk("mul_nostall_id", {31'd0, stall}, 32'd0);
    tick();
    chk("mul_start", {31'd0, ex_start}, 32'd1);
    chk("mul_res", {30'd0, ex_res}, 32'd3);
    chk("mul_stall", {31'd0, stall}, 32'd0);
    chk("nm_mul_illegal", {31'd0, nm_ill}, 32'd1);
    chk("nm_mul_rw", {31'd0, nm_rw}, 32'd0);
    chk("nm_mul_stall", {31'd0, nm_stall}, 32'd0);
    instr = I_NOP; tick();
    chk("mul_start_drop", {31'd0, ex_start}, 32'd0);

    // Flush on cycle 10 of a DIV
    instr = I_DIV; tick();
    instr = I_NOP;
    repeat (9) tick();
    chk("div10_stall", {31'd0, stall}, 32'd1);
    flush = 1'b1; #1;
    chk("flush_stall", {31'd0, stall}, 32'd0);
    tick();
    flush = 1'b0; #1;
    chk("flush_bubble", {31'd0, ex_valid}, 32'd0);
    chk("flush_res", {30'd0, ex_res}, 32'd0);
    chk("flush_run", {31'd0, stall}, 32'd0);
    tick();
    chk("flush_next_valid", {31'd0, ex_valid}, 32'd1);

    // Flush together with load-use: flush wins
    instr = I_LW_X5; tick();
    instr = I_ADD; flush = 1'b1; #1;
    chk("flush_lu_stall", {31'd0, stall}, 32'd0);
    tick();
    flush = 1'b0; #1;
    chk("flush_lu_bubble", {31'd0, ex_valid}, 32'd0);
    chk("flush_lu_nostall", {31'd0, stall}, 32'd0);
    tick();
    chk("flush_lu_add_rd", {27'd0, ex_rd}, 32'd6);

    // Decode sweep
    instr = I_SRAI; #1;
    chk("srai_imm", {29'd0, imm_src}, 32'd1);
    tick();
    chk("srai_alu", {28'd0, ex_alu}, 32'h7);
    chk("srai_srcb", {31'd0, ex_sb}, 32'd1);
    chk("srai_rd", {27'd0, ex_rd}, 32'd1);
    instr = I_AUIPC; #1;
    chk("auipc_imm", {29'd0, imm_src}, 32'd4);
    tick();
    chk("auipc_srca", {31'd0, ex_sa}, 32'd1);
    chk("auipc_alu", {28'd0, ex_alu}, 32'd0);
    chk("auipc_rd", {27'd0, ex_rd}, 32'd7);
    instr = I_SW; #1;
    chk("sw_imm", {29'd0, imm_src}, 32'd2);
    tick();
    chk("sw_mw", {31'd0, ex_mw}, 32'd1);
    chk("sw_rw", {31'd0, ex_rw}, 32'd0);
    instr = I_BAD; tick();
    chk("bad_illegal", {31'd0, ex_ill}, 32'd1);
    chk("bad_valid", {31'd0, ex_valid}, 32'd1);
    chk("bad_enables", {30'd0, ex_rw, ex_mw}, 32'd0);
    instr = I_SLLI_BAD; tick();
    chk("slli_bad_illegal", {31'd0, ex_ill}, 32'd1);
    chk("slli_bad_rw", {31'd0, ex_rw}, 32'd0);

    // Reset during MDU_BUSY
    instr = I_DIV; tick();
    instr = I_NOP; tick();
    rst = 1'b1; tick();
    chk("rst_busy_valid", {31'd0, ex_valid}, 32'd0);
    chk("rst_busy_res", {30'd0, ex_res}, 32'd0);
    rst = 1'b0; #1;
    chk("rst_busy_stall", {31'd0, stall}, 32'd0);

    // Reset during a load-use stall
    instr = I_LW_X5; tick();
    instr = I_ADD; #1;
    chk("rst_lu_pre", {31'd0, stall}, 32'd1);
    rst = 1'b1; tick();
    rst = 1'b0; #1;
    chk("rst_lu_valid", {31'd0, ex_valid}, 32'd0);
    chk("rst_lu_stall", {31'd0, stall}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
